// File: rtl/parameterizable_down_counter_timer.sv
// parameterizable_down_counter_timer
//
// Loadable countdown timer. A programmed value is counted down to zero at a
// prescaled rate, and completion is flagged with a one-cycle pulse. Counting
// can be paused and resumed. With auto-reload the counter restarts from the
// reload register at terminal count, which gives a periodic tick.
//
// Parameters
//   N_BITS    width of the count, the reload register and load_value
//   PRESCALE  clk cycles per decrement while running (>= 1)
//
// Ports
//   clk           rising-edge clock, single clock domain
//   sync_reset_n  synchronous active-low reset
//   load_enable   write load_value into the reload register and the counter
//   load_value    value to load
//   start         start from IDLE, resume from PAUSED, restart from DONE
//   pause         freeze counting while RUNNING
//   auto_reload   at terminal count, reload instead of stopping
//   counter_out   current count (registered)
//   busy          high in RUNNING or PAUSED
//   done          one-cycle terminal-count pulse (registered)
//   state_out     IDLE=0, RUNNING=1, PAUSED=2, DONE=3

module parameterizable_down_counter_timer #(
  parameter int N_BITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic              load_enable,
  input  logic [N_BITS-1:0] load_value,
  input  logic              start,
  input  logic              pause,
  input  logic              auto_reload,
  output logic [N_BITS-1:0] counter_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_out
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [N_BITS-1:0] CNT_ONE  = N_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] count_q, count_d;
  logic [N_BITS-1:0] reload_q, reload_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    done_d   = 1'b0;

    if (load_enable) begin
      count_d  = load_value;
      reload_d = load_value;
      pre_d    = '0;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = S_RUNNING;
              pre_d   = '0;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end

        S_RUNNING: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else begin
              // Terminal step; a zero count is treated the same so the
              // counter can never wrap below zero.
              done_d = 1'b1;
              if (auto_reload && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end

        S_PAUSED: begin
          // Prescaler is left untouched so the phase carries over on resume.
          if (start && !pause) begin
            state_d = S_RUNNING;
          end
        end

        S_DONE: begin
          count_d = '0;
          if (start && (reload_q != '0)) begin
            count_d = reload_q;
            pre_d   = '0;
            state_d = S_RUNNING;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end

  assign counter_out = count_q;
  assign busy        = (state_q == S_RUNNING) || (state_q == S_PAUSED);
  assign done        = done_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_parameterizable_down_counter_timer.sv
// Testbench for parameterizable_down_counter_timer.
// Two instances share the same stimulus: dut1 uses PRESCALE=1, dut3 uses
// PRESCALE=3. A vector table drives most of dut1's behaviour; hand-written
// sequences cover the prescaled timing, the pause phase retention, the full
// count from the maximum value and reset glitches between edges.

module tb_parameterizable_down_counter_timer;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PAU  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic       load_enable;
  logic [3:0] load_value;
  logic       start;
  logic       pause;
  logic       auto_reload;

  logic [3:0] cnt1, cnt3;
  logic       busy1, busy3, done1, done3;
  logic [1:0] st1, st3;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic       rst_n;
    logic       load_en;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       ar;
    logic [3:0] exp_cnt;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  parameterizable_down_counter_timer #(.N_BITS(4), .PRESCALE(1)) dut1 (
    .clk(clk), .sync_reset_n(sync_reset_n), .load_enable(load_enable),
    .load_value(load_value), .start(start), .pause(pause),
    .auto_reload(auto_reload), .counter_out(cnt1), .busy(busy1),
    .done(done1), .state_out(st1)
  );

  parameterizable_down_counter_timer #(.N_BITS(4), .PRESCALE(3)) dut3 (
    .clk(clk), .sync_reset_n(sync_reset_n), .load_enable(load_enable),
    .load_value(load_value), .start(start), .pause(pause),
    .auto_reload(auto_reload), .counter_out(cnt3), .busy(busy3),
    .done(done3), .state_out(st3)
  );

  task automatic addVec(input logic rst_n, input logic le, input logic [3:0] lv,
                        input logic st, input logic pa, input logic ar,
                        input logic [3:0] ec, input logic eb, input logic ed,
                        input logic [1:0] es);
    vec_t v;
    v.rst_n = rst_n; v.load_en = le; v.load_val = lv; v.start = st;
    v.pause = pa; v.ar = ar; v.exp_cnt = ec; v.exp_busy = eb;
    v.exp_done = ed; v.exp_state = es;
    vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, then advance past the next edge.
  task automatic applyStimulus(input logic rst_n, input logic le, input logic [3:0] lv,
                               input logic st, input logic pa, input logic ar);
    sync_reset_n = rst_n;
    load_enable  = le;
    load_value   = lv;
    start        = st;
    pause        = pa;
    auto_reload  = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int which,
                             input logic [3:0] ec, input logic eb,
                             input logic ed, input logic [1:0] es);
    logic [3:0] c;
    logic       b, d;
    logic [1:0] s;
    if (which == 3) begin
      c = cnt3; b = busy3; d = done3; s = st3;
    end else begin
      c = cnt1; b = busy1; d = done1; s = st1;
    end
    checks += 4;
    if (c !== ec) begin
      fails++;
      $display("[TB] FAIL %s counter: got %0d expected %0d", name, c, ec);
    end
    if (b !== eb) begin
      fails++;
      $display("[TB] FAIL %s busy: got %0b expected %0b", name, b, eb);
    end
    if (d !== ed) begin
      fails++;
      $display("[TB] FAIL %s done: got %0b expected %0b", name, d, ed);
    end
    if (s !== es) begin
      fails++;
      $display("[TB] FAIL %s state: got %0d expected %0d", name, s, es);
    end
  endtask

  initial begin
    sync_reset_n = 1'b0;
    load_enable  = 1'b0;
    load_value   = 4'd0;
    start        = 1'b0;
    pause        = 1'b0;
    auto_reload  = 1'b0;

    //     rst le  lv    st pa ar   cnt  busy done state
    // basic countdown 3,2,1,0
    addVec(0, 0, 4'd0, 0, 0, 0,  4'd0, 0, 0, ST_IDLE);
    addVec(1, 1, 4'd3, 0, 0, 0,  4'd3, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd3, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd2, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd1, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd0, 0, 1, ST_DONE);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd0, 0, 0, ST_DONE);
    // auto-reload 2,1,2,1 with done on each 1->2
    addVec(1, 1, 4'd2, 0, 0, 1,  4'd2, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 1,  4'd2, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 1,  4'd1, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 1,  4'd2, 1, 1, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 1,  4'd1, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 1,  4'd2, 1, 1, ST_RUN);
    // pause at 3 for 4 cycles, resume -> 2,1,0
    addVec(1, 1, 4'd5, 0, 0, 0,  4'd5, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd5, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd4, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd3, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 1, 0,  4'd3, 1, 0, ST_PAU);
    addVec(1, 0, 4'd0, 0, 1, 0,  4'd3, 1, 0, ST_PAU);
    addVec(1, 0, 4'd0, 1, 1, 0,  4'd3, 1, 0, ST_PAU);
    addVec(1, 0, 4'd0, 0, 1, 0,  4'd3, 1, 0, ST_PAU);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd3, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd2, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd1, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd0, 0, 1, ST_DONE);
    // load beats start mid-count; reset mid-count; start at zero
    addVec(1, 1, 4'd7, 0, 0, 0,  4'd7, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd7, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd6, 1, 0, ST_RUN);
    addVec(1, 1, 4'd9, 1, 0, 0,  4'd9, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd9, 1, 0, ST_RUN);
    addVec(1, 0, 4'd0, 0, 0, 0,  4'd8, 1, 0, ST_RUN);
    addVec(0, 1, 4'd5, 1, 0, 0,  4'd0, 0, 0, ST_IDLE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd0, 0, 1, ST_DONE);
    addVec(1, 0, 4'd0, 1, 0, 0,  4'd0, 0, 0, ST_DONE);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].load_en, vecs[i].load_val,
                    vecs[i].start, vecs[i].pause, vecs[i].ar);
      checkOutput($sformatf("vec%0d", i), 1, vecs[i].exp_cnt, vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_state);
    end

    // Full countdown from the maximum value, then restart from DONE.
    $display("[TB] full-range countdown");
    applyStimulus(1, 1, 4'd15, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("max_start", 1, 4'd15, 1, 0, ST_RUN);
    for (int k = 14; k >= 0; k--) begin
      applyStimulus(1, 0, 4'd0, 0, 0, 0);
      if (k == 0) checkOutput("max_end", 1, 4'd0, 0, 1, ST_DONE);
      else        checkOutput($sformatf("max_%0d", k), 1, 4'(k), 1, 0, ST_RUN);
    end
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("max_hold", 1, 4'd0, 0, 0, ST_DONE);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("done_restart", 1, 4'd15, 1, 0, ST_RUN);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("restart_step", 1, 4'd14, 1, 0, ST_RUN);
    applyStimulus(1, 1, 4'd0, 0, 0, 0);
    checkOutput("load_zero", 1, 4'd0, 0, 0, ST_IDLE);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("start_zero", 1, 4'd0, 0, 1, ST_DONE);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("pulse_once", 1, 4'd0, 0, 0, ST_DONE);

    // A reset pulse that rises again before the edge must be ignored.
    $display("[TB] reset glitch between edges");
    applyStimulus(1, 1, 4'd4, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("glitch_start", 1, 4'd4, 1, 0, ST_RUN);
    start = 1'b0;
    @(negedge clk);
    sync_reset_n = 1'b0;
    #2;
    sync_reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("glitch_ignored", 1, 4'd3, 1, 0, ST_RUN);

    // Prescaled countdown on dut3: 2 for 3 cycles, 1 for 3 cycles, then 0.
    $display("[TB] prescale 3 countdown");
    applyStimulus(0, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_reset", 3, 4'd0, 0, 0, ST_IDLE);
    applyStimulus(1, 1, 4'd2, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("p3_a0", 3, 4'd2, 1, 0, ST_RUN);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_a1", 3, 4'd2, 1, 0, ST_RUN);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_a2", 3, 4'd2, 1, 0, ST_RUN);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 4'd0, 0, 0, 0);
      checkOutput($sformatf("p3_b%0d", k), 3, 4'd1, 1, 0, ST_RUN);
    end
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_done", 3, 4'd0, 0, 1, ST_DONE);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_done_clr", 3, 4'd0, 0, 0, ST_DONE);

    // Prescaler phase survives a pause: one tick before the pause plus one
    // after resume leaves a single tick before the step.
    $display("[TB] prescale 3 pause phase");
    applyStimulus(1, 1, 4'd2, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 0, 1, 0);
    checkOutput("p3_paused", 3, 4'd2, 1, 0, ST_PAU);
    applyStimulus(1, 0, 4'd0, 0, 1, 0);
    applyStimulus(1, 0, 4'd0, 1, 0, 0);
    checkOutput("p3_resumed", 3, 4'd2, 1, 0, ST_RUN);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_phase1", 3, 4'd2, 1, 0, ST_RUN);
    applyStimulus(1, 0, 4'd0, 0, 0, 0);
    checkOutput("p3_phase_step", 3, 4'd1, 1, 0, ST_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
